// File: rtl/mini_cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, datapath widths and the result-stage entry layout.
package mini_cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 4;
  localparam int OP_W   = 5;

  localparam logic [OP_W-1:0] OP_AND = 5'b00000;
  localparam logic [OP_W-1:0] OP_OR  = 5'b00001;
  localparam logic [OP_W-1:0] OP_XOR = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB = 5'b00100;
  localparam logic [OP_W-1:0] OP_SHL = 5'b00101;
  localparam logic [OP_W-1:0] OP_SHR = 5'b00110;
  localparam logic [OP_W-1:0] OP_SRA = 5'b00111;
  localparam logic [OP_W-1:0] OP_ROL = 5'b01000;
  localparam logic [OP_W-1:0] OP_ROR = 5'b01001;
  localparam logic [OP_W-1:0] OP_NEG = 5'b01010;
  localparam logic [OP_W-1:0] OP_NOT = 5'b01011;
  localparam logic [OP_W-1:0] OP_MUL = 5'b01111;
  localparam logic [OP_W-1:0] OP_DIV = 5'b10000;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] zhigh;
    logic [DATA_W-1:0] zlow;
    logic [REG_W-1:0]  dest;
  } entry_t;

  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Generic DEPTH-entry FIFO with registered head (no fall-through) and synchronous active-low reset.
module result_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q];

  always_comb begin
    wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = do_pop  ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result buffer: retires mul/div into HI/LO internally, hands other results to writeback in order.
// Optional condition flags (flag_z/flag_n) are built when CC_FLAGS_EN is defined.
module alu_result_stage
  import mini_cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
`ifdef CC_FLAGS_EN
  output logic              flag_z,
  output logic              flag_n,
`endif
  input  logic              clock,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] Zlow_in,
  input  logic [DATA_W-1:0] Zhigh_in,
  input  logic [REG_W-1:0]  dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_dest,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO
);

  entry_t            push_entry, head;
  logic              fifo_full, fifo_empty;
  logic              push, pop, head_muldiv, wb_fire;
  logic              rdy_q;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;

  assign push_entry = '{op: op, zhigh: Zhigh_in, zlow: Zlow_in, dest: dest};

  // rdy_q keeps in_ready low through reset and for the edge that leaves it.
  assign in_ready = rdy_q && !fifo_full;
  assign push     = in_valid && in_ready;

  result_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t))
  ) u_fifo (
    .clk   (clock),
    .rst_n (clear),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    head_muldiv = !fifo_empty && is_muldiv(head.op);
    out_valid   = !fifo_empty && !is_muldiv(head.op);
    wb_data     = out_valid ? head.zlow : '0;
    wb_dest     = out_valid ? head.dest : '0;
    wb_fire     = out_valid && out_ready;
    pop         = head_muldiv || wb_fire;
    hi_d        = head_muldiv ? head.zhigh : hi_q;
    lo_d        = head_muldiv ? head.zlow  : lo_q;
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      rdy_q <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      rdy_q <= 1'b1;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

`ifdef CC_FLAGS_EN
  logic flag_z_q, flag_n_q;

  always_ff @(posedge clock) begin
    if (!clear) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else if (wb_fire) begin
      flag_z_q <= (wb_data == '0);
      flag_n_q <= wb_data[DATA_W-1];
    end
  end

  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
`endif

endmodule
